// File: rtl/writeback_stage_pl_pkg.sv
// Shared definitions for the writeback stage: result-source encodings, FSM states
// and the load-classification helper.
package wb_pkg;

  typedef enum logic [2:0] {
    RS_ALU = 3'd0,
    RS_LUI = 3'd1,
    RS_LB  = 3'd2,
    RS_LH  = 3'd3,
    RS_LW  = 3'd4,
    RS_LBU = 3'd5,
    RS_LHU = 3'd6,
    RS_PC4 = 3'd7
  } result_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } wb_state_e;

  function automatic logic is_load(input logic [2:0] src);
    return (src >= RS_LB) && (src <= RS_LHU);
  endfunction

endpackage

// File: rtl/writeback_stage_pl_if.sv
// Memory-stage to writeback-stage bundle, plus the load-data return and W outputs.
// Handshake: an instruction presented with validM is taken at a clock edge only
// while stallW2H is low; load data is taken in any cycle mem_rvalid is high while a
// load is resident, and the commit happens in that same cycle.
interface writeback_stage_pl_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  validM;
  logic                  flushW;
  logic [XLEN-1:0]       ALUOutM;
  logic [XLEN-1:0]       LUI_or_AUIPCM;
  logic [XLEN-1:0]       PCPlus4M;
  logic [2:0]            ResultSrcM;
  logic                  RegWriteM;
  logic [REG_ADDR_W-1:0] rdM;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       ResultW;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] rdW;
  logic                  stallW2H;
  logic                  load_timeoutW;

  modport master (
    output validM, flushW, ALUOutM, LUI_or_AUIPCM, PCPlus4M, ResultSrcM, RegWriteM, rdM,
           mem_rdata, mem_rvalid,
    input  ResultW, RegWriteW, rdW, stallW2H, load_timeoutW
  );

  modport slave (
    input  validM, flushW, ALUOutM, LUI_or_AUIPCM, PCPlus4M, ResultSrcM, RegWriteM, rdM,
           mem_rdata, mem_rvalid,
    output ResultW, RegWriteW, rdW, stallW2H, load_timeoutW
  );
endinterface

// File: rtl/writeback_stage_pl_load_align.sv
// Load alignment: picks the addressed byte/half out of a word-aligned read and
// sign- or zero-extends it to XLEN.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] data
);
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Halves only look at offset[1]; a misaligned half is the memory stage's concern.
  assign byte_val = rdata[{offset, 3'b000} +: 8];
  assign half_val = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    case (src)
      RS_LB:   data = XLEN'($signed(byte_val));
      RS_LH:   data = XLEN'($signed(half_val));
      RS_LW:   data = XLEN'($signed(rdata));
      RS_LBU:  data = XLEN'(byte_val);
      RS_LHU:  data = XLEN'(half_val);
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/writeback_stage_pl.sv
// Writeback stage: MEM/WB register, variable-latency load return, result mux.
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module writeback_stage_pl
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_stage_pl_if.slave  wb,
  output wb_state_e            state
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          load_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [XLEN-1:0]       alu_q, lui_q, pc4_q;
  logic [2:0]            src_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  timeout_q;

  logic                  resident, stall, commit;
  logic [XLEN-1:0]       load_data, result;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata  (wb.mem_rdata),
    .offset (alu_q[1:0]),
    .src    (src_q),
    .data   (load_data)
  );

  // A resident load stalls in any cycle its data has not come back yet.
  assign resident = (state != ST_EMPTY);
  assign stall    = resident && is_load(src_q) && !wb.mem_rvalid;
  assign commit   = resident && !stall;

  always_comb begin
    result = load_data;
    case (src_q)
      RS_ALU:  result = alu_q;
      RS_LUI:  result = lui_q;
      RS_PC4:  result = pc4_q;
      default: result = load_data;
    endcase
  end

  assign wb.ResultW       = result;
  assign wb.RegWriteW     = commit && regwrite_q && (rd_q != '0);
  assign wb.rdW           = rd_q;
  assign wb.stallW2H      = stall;
  assign wb.load_timeoutW = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      alu_q      <= '0;
      lui_q      <= '0;
      pc4_q      <= '0;
      src_q      <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
    end else if (stall) begin
      state <= ST_WAIT_LOAD;
      if (state != ST_WAIT_LOAD) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) timeout_q <= 1'b1;
      end
    end else begin
      state      <= (wb.validM && !wb.flushW) ? ST_ACTIVE : ST_EMPTY;
      alu_q      <= wb.ALUOutM;
      lui_q      <= wb.LUI_or_AUIPCM;
      pc4_q      <= wb.PCPlus4M;
      src_q      <= wb.ResultSrcM;
      regwrite_q <= wb.RegWriteM;
      rd_q       <= wb.rdM;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Retired counts every commit, even those that do not write the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt    <= '0;
      load_stall_cnt <= '0;
    end else begin
      if (commit) retired_cnt <= retired_cnt + 32'd1;
      if (stall) load_stall_cnt <= load_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_writeback_stage_pl.sv
// Bench for writeback_stage_pl: directed scenarios plus a randomized run against a
// transaction-level model (resident instruction + remaining load latency).
module tb_writeback_stage_pl;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int MAXW = 4;

  logic      clk = 1'b0;
  logic      reset;
  wb_state_e state;
  int        checks = 0;
  int        errors = 0;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_cnt, load_stall_cnt;
`endif

  writeback_stage_pl_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) wb_if ();

  writeback_stage_pl #(.XLEN(XLEN), .REG_ADDR_W(RW), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if),
    .state (state)
`ifdef WB_PERF_CNT_EN
    ,
    .retired_cnt    (retired_cnt),
    .load_stall_cnt (load_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    bit          valid;
    bit          flush;
    logic [2:0]  src;
    logic [31:0] alu, lui, pc4, word;
    logic [4:0]  rd;
    bit          rw;
    int          delay;
  } instr_t;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit valid, input bit flush, input logic [2:0] src,
                         input logic [31:0] alu, input logic [31:0] lui,
                         input logic [31:0] pc4, input logic [4:0] rd, input bit rw);
    wb_if.validM        = valid;
    wb_if.flushW        = flush;
    wb_if.ResultSrcM    = src;
    wb_if.ALUOutM       = alu;
    wb_if.LUI_or_AUIPCM = lui;
    wb_if.PCPlus4M      = pc4;
    wb_if.rdM           = rd;
    wb_if.RegWriteM     = rw;
  endtask

  task automatic idle_m();
    drive_m(1'b0, 1'b0, 3'd0, $urandom, $urandom, $urandom, 5'($urandom), 1'b1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_m();
    wb_if.mem_rvalid = 1'b0;
    wb_if.mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input instr_t t);
    longint unsigned w, b, h;
    int off;
    w   = t.word;
    off = int'(t.alu % 4);
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (16 * (off / 2))) % 65536;
    case (t.src)
      3'd0: return t.alu;
      3'd1: return t.lui;
      3'd7: return t.pc4;
      3'd2: return (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
      3'd3: return (h >= 32768) ? (32'(h) | 32'hFFFF_0000) : 32'(h);
      3'd4: return t.word;
      3'd5: return 32'(b);
      default: return 32'(h);
    endcase
  endfunction

  function automatic instr_t new_instr();
    instr_t t;
    t.valid = ($urandom_range(0, 7) != 0);
    t.flush = ($urandom_range(0, 7) == 0);
    t.src   = 3'($urandom_range(0, 7));
    t.alu   = $urandom;
    t.lui   = $urandom;
    t.pc4   = $urandom;
    t.word  = $urandom;
    t.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    t.rw    = ($urandom_range(0, 5) != 0);
    t.delay = $urandom_range(0, 3);
    return t;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_m();
    wb_if.mem_rvalid = 1'b1;
    wb_if.mem_rdata  = 32'hFFFF_FFFF;
    #3;
    checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b exp 0", wb_if.RegWriteW); end
    checks++; if (wb_if.stallW2H !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", wb_if.stallW2H); end
    checks++; if (wb_if.ResultW !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", wb_if.ResultW); end
    checks++; if (wb_if.rdW !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", wb_if.rdW); end
    checks++; if (wb_if.load_timeoutW !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", wb_if.load_timeoutW); end
    checks++; if (state !== ST_EMPTY) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, ST_EMPTY); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== 32'd0 || load_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", retired_cnt, load_stall_cnt); end
`endif
    apply_reset();
  endtask

  task automatic test_alu();
    drive_m(1'b1, 1'b0, RS_ALU, 32'h1234, $urandom, $urandom, 5'd5, 1'b1);
    next_cycle();
    idle_m();
    wb_if.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %0b exp 1", wb_if.RegWriteW); end
    checks++; if (wb_if.ResultW !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", wb_if.ResultW); end
    checks++; if (wb_if.rdW !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", wb_if.rdW); end
    checks++; if (wb_if.stallW2H !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b exp 0", wb_if.stallW2H); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL alu_single_pulse got %0b exp 0", wb_if.RegWriteW); end
    next_cycle();
  endtask

  task automatic test_lb_lbu();
    logic [2:0]  srcs [2];
    logic [31:0] exps [2];
    srcs[0] = RS_LB;  exps[0] = 32'hFFFF_FFFF;
    srcs[1] = RS_LBU; exps[1] = 32'h0000_00FF;
    for (int i = 0; i < 2; i++) begin
      drive_m(1'b1, 1'b0, srcs[i], 32'h0000_1002, $urandom, $urandom, 5'd7, 1'b1);
      next_cycle();
      idle_m();
      wb_if.mem_rdata  = 32'h80FF_0000;
      wb_if.mem_rvalid = 1'b1;
      @(negedge clk);
      checks++; if (wb_if.RegWriteW !== 1'b1) begin errors++; $display("FAIL byte_regwrite[%0d] got %0b exp 1", i, wb_if.RegWriteW); end
      checks++; if (wb_if.ResultW !== exps[i]) begin errors++; $display("FAIL byte_result[%0d] got %h exp %h", i, wb_if.ResultW, exps[i]); end
      checks++; if (wb_if.stallW2H !== 1'b0) begin errors++; $display("FAIL byte_stall[%0d] got %0b exp 0", i, wb_if.stallW2H); end
      next_cycle();
      wb_if.mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_lhu_delay();
    drive_m(1'b1, 1'b0, RS_LHU, 32'h0000_0102, $urandom, $urandom, 5'd12, 1'b1);
    next_cycle();
    // Upstream holds its next instruction while W is stalled.
    drive_m(1'b1, 1'b0, RS_ALU, 32'hCAFE_0009, $urandom, $urandom, 5'd9, 1'b1);
    wb_if.mem_rvalid = 1'b0;
    wb_if.mem_rdata  = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wb_if.stallW2H !== 1'b1) begin errors++; $display("FAIL lhu_stall[%0d] got %0b exp 1", k, wb_if.stallW2H); end
      checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL lhu_early_commit[%0d] got %0b exp 0", k, wb_if.RegWriteW); end
      next_cycle();
    end
    wb_if.mem_rvalid = 1'b1;
    wb_if.mem_rdata  = 32'h80FF_0000;
    @(negedge clk);
    checks++; if (wb_if.stallW2H !== 1'b0) begin errors++; $display("FAIL lhu_stall_end got %0b exp 0", wb_if.stallW2H); end
    checks++; if (wb_if.RegWriteW !== 1'b1) begin errors++; $display("FAIL lhu_commit got %0b exp 1", wb_if.RegWriteW); end
    checks++; if (wb_if.ResultW !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_result got %h exp 000080ff", wb_if.ResultW); end
    checks++; if (wb_if.rdW !== 5'd12) begin errors++; $display("FAIL lhu_rd got %0d exp 12", wb_if.rdW); end
    next_cycle();
    idle_m();
    wb_if.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b1 || wb_if.rdW !== 5'd9) begin errors++; $display("FAIL held_instr got we=%0b rd=%0d exp we=1 rd=9", wb_if.RegWriteW, wb_if.rdW); end
    checks++; if (wb_if.ResultW !== 32'hCAFE_0009) begin errors++; $display("FAIL held_result got %h exp cafe0009", wb_if.ResultW); end
    next_cycle();
  endtask

  task automatic test_x0_flush();
    drive_m(1'b1, 1'b0, RS_ALU, $urandom, $urandom, $urandom, 5'd0, 1'b1);
    next_cycle();
    drive_m(1'b1, 1'b1, RS_ALU, $urandom, $urandom, $urandom, 5'd3, 1'b1);
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL x0_commit got %0b exp 0", wb_if.RegWriteW); end
    next_cycle();
    idle_m();
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_commit got %0b exp 0", wb_if.RegWriteW); end
    checks++; if (state !== ST_EMPTY) begin errors++; $display("FAIL flush_state got %0d exp %0d", state, ST_EMPTY); end
    next_cycle();
  endtask

  task automatic test_random();
    instr_t res, pend;
    bit     have, is_ld, exp_stall, exp_we;
    int     exp_retired, exp_stalls;
    logic [31:0] exp_res;
    apply_reset();
    have = 1'b0;
    res  = new_instr();
    pend = new_instr();
    exp_retired = 0;
    exp_stalls  = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      is_ld     = have && (res.src >= 3'd2) && (res.src <= 3'd6);
      exp_stall = is_ld && (res.delay != 0);
      exp_we    = have && !exp_stall && res.rw && (res.rd != 5'd0);
      if (exp_stall)
        drive_m(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'b1);
      else
        drive_m(pend.valid, pend.flush, pend.src, pend.alu, pend.lui, pend.pc4, pend.rd, pend.rw);
      if (is_ld) begin
        wb_if.mem_rvalid = !exp_stall;
        wb_if.mem_rdata  = exp_stall ? $urandom : res.word;
      end else begin
        wb_if.mem_rvalid = 1'($urandom);
        wb_if.mem_rdata  = $urandom;
      end
      @(negedge clk);
      checks++; if (wb_if.stallW2H !== exp_stall) begin errors++; $display("FAIL rand_stall cyc %0d got %0b exp %0b", cyc, wb_if.stallW2H, exp_stall); end
      checks++; if (wb_if.RegWriteW !== exp_we) begin errors++; $display("FAIL rand_regwrite cyc %0d got %0b exp %0b", cyc, wb_if.RegWriteW, exp_we); end
      checks++; if (wb_if.load_timeoutW !== 1'b0) begin errors++; $display("FAIL rand_timeout cyc %0d got %0b exp 0", cyc, wb_if.load_timeoutW); end
      if (exp_we) begin
        exp_res = ref_result(res);
        checks++; if (wb_if.rdW !== res.rd) begin errors++; $display("FAIL rand_rd cyc %0d got %0d exp %0d", cyc, wb_if.rdW, res.rd); end
        checks++; if (wb_if.ResultW !== exp_res) begin errors++; $display("FAIL rand_result cyc %0d src %0d got %h exp %h", cyc, res.src, wb_if.ResultW, exp_res); end
      end
      if (have && !exp_stall) exp_retired++;
      if (exp_stall) exp_stalls++;
      next_cycle();
      if (exp_stall) begin
        res.delay--;
      end else begin
        have = pend.valid && !pend.flush;
        res  = pend;
        pend = new_instr();
      end
    end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== 32'(exp_retired)) begin errors++; $display("FAIL perf_retired got %0d exp %0d", retired_cnt, exp_retired); end
    checks++; if (load_stall_cnt !== 32'(exp_stalls)) begin errors++; $display("FAIL perf_stalls got %0d exp %0d", load_stall_cnt, exp_stalls); end
`endif
    apply_reset();
  endtask

  task automatic test_timeout();
    bit exp_to;
    drive_m(1'b1, 1'b0, RS_LW, 32'h0000_2000, $urandom, $urandom, 5'd4, 1'b1);
    next_cycle();
    idle_m();
    wb_if.mem_rvalid = 1'b0;
    // Cycle 1 is the first W cycle; later stalled cycles are the counted waits.
    for (int c = 1; c <= 6; c++) begin
      exp_to = ((c - 2) >= MAXW);
      @(negedge clk);
      checks++; if (wb_if.stallW2H !== 1'b1) begin errors++; $display("FAIL to_stall[%0d] got %0b exp 1", c, wb_if.stallW2H); end
      checks++; if (wb_if.load_timeoutW !== exp_to) begin errors++; $display("FAIL to_flag[%0d] got %0b exp %0b", c, wb_if.load_timeoutW, exp_to); end
      next_cycle();
    end
    wb_if.mem_rvalid = 1'b1;
    wb_if.mem_rdata  = 32'h1357_9BDF;
    @(negedge clk);
    checks++; if (wb_if.RegWriteW !== 1'b1 || wb_if.ResultW !== 32'h1357_9BDF) begin errors++; $display("FAIL to_commit got we=%0b res=%h exp we=1 res=13579bdf", wb_if.RegWriteW, wb_if.ResultW); end
    next_cycle();
    wb_if.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (wb_if.load_timeoutW !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", wb_if.load_timeoutW); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    drive_m(1'b1, 1'b0, RS_LW, 32'h0000_3000, $urandom, $urandom, 5'd6, 1'b1);
    next_cycle();
    idle_m();
    wb_if.mem_rvalid = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (state !== ST_WAIT_LOAD || wb_if.stallW2H !== 1'b1) begin errors++; $display("FAIL mid_wait got state=%0d stall=%0b exp state=%0d stall=1", state, wb_if.stallW2H, ST_WAIT_LOAD); end
    reset = 1'b1;
    #1;
    checks++; if (wb_if.stallW2H !== 1'b0 || wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL async_reset_ctl got stall=%0b we=%0b exp 0/0", wb_if.stallW2H, wb_if.RegWriteW); end
    checks++; if (wb_if.ResultW !== 32'h0 || wb_if.rdW !== 5'd0) begin errors++; $display("FAIL async_reset_data got res=%h rd=%0d exp 0/0", wb_if.ResultW, wb_if.rdW); end
    checks++; if (wb_if.load_timeoutW !== 1'b0 || state !== ST_EMPTY) begin errors++; $display("FAIL async_reset_state got to=%0b state=%0d exp 0/%0d", wb_if.load_timeoutW, state, ST_EMPTY); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== 32'd0 || load_stall_cnt !== 32'd0) begin errors++; $display("FAIL async_reset_perf got %0d/%0d exp 0/0", retired_cnt, load_stall_cnt); end
`endif
    next_cycle();
    reset = 1'b0;
    wb_if.mem_rvalid = 1'b1;
    wb_if.mem_rdata  = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wb_if.RegWriteW !== 1'b0) begin errors++; $display("FAIL post_reset_commit[%0d] got %0b exp 0", k, wb_if.RegWriteW); end
      next_cycle();
    end
    wb_if.mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_lbu();
    test_lhu_delay();
    test_x0_flush();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage_pl.md
Name: writeback_stage_pl

Overview:
Parametrised next-generation writeback stage: owns the MEM/WB pipeline register and selects the register-file result. It adds variable-latency load-data return (valid handshake) and byte-offset load alignment. Commit is suppressed for x0. It raises a stall toward the hazard unit while a load is outstanding. Sits between the memory stage and the register file / forwarding paths.

Parameters:
XLEN, 32, datapath width (32 or 64; lwu/ld not supported, XLEN=64 sign/zero-extends to 64)
REG_ADDR_W, 5, register index width
MAX_WAIT, 255, load-wait cycles before error flag; counter width = $clog2(MAX_WAIT+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
validM  in  1  memory stage presents an instruction
flushW  in  1  discard the instruction being captured this cycle (bubble)
ALUOutM  in  XLEN  ALU result / load address
LUI_or_AUIPCM  in  XLEN  LUI/AUIPC value
PCPlus4M  in  XLEN  link value
ResultSrcM  in  3  0 ALU, 1 LUI/AUIPC, 2 lb, 3 lh, 4 lw, 5 lbu, 6 lhu, 7 PC+4
RegWriteM  in  1  register write request
rdM  in  REG_ADDR_W  destination
mem_rdata  in  32  load data word (word-aligned)
mem_rvalid  in  1  load data valid this cycle
ResultW  out  XLEN  write data (to regfile and execute forwarding)
RegWriteW  out  1  commit strobe, one cycle per instruction
rdW  out  REG_ADDR_W  destination
stallW2H  out  1  W waiting for load data; upstream must hold
load_timeoutW  out  1  sticky: wait exceeded MAX_WAIT

Behaviour:
- States: EMPTY, ACTIVE, WAIT_LOAD. Reset (async): state EMPTY, all registers 0, all outputs 0, load_timeoutW 0.
- Capture: when stallW2H=0, register loads M inputs at the clock edge. Next state is ACTIVE if validM && !flushW, else EMPTY. With stallW2H=1, the register holds and M inputs are ignored.
- Load = ResultSrc in {2,3,4,5,6}.
- ACTIVE, non-load: RegWriteW = RegWrite && (rd!=0) this cycle; next state follows the capture rule.
- ACTIVE/WAIT_LOAD, load:
  - mem_rvalid=1: commit this cycle, stallW2H=0, next state follows the capture rule.
  - mem_rvalid=0: stallW2H=1 (combinational), RegWriteW=0, next WAIT_LOAD.
- Alignment: offset = ALUOut[1:0].
  - byte = mem_rdata >> (8*offset).
  - half = mem_rdata >> (16*offset[1]); offset[0] ignored for halves, offset ignored for lw.
  - Misaligned accesses are the memory stage's problem.
- Extension: lb/lh sign-extend to XLEN; lbu/lhu zero-extend; lw sign-extends when XLEN=64.
- ResultW is valid whenever RegWriteW=1; otherwise it follows the mux but is don't-care.
- Wait counter: clears on entering WAIT_LOAD, increments each WAIT_LOAD cycle, saturates. On reaching MAX_WAIT, load_timeoutW sets; cleared only by reset.
- flushW while stallW2H=1 is ignored; flush never cancels the resident load.
- mem_rvalid in EMPTY or with a non-load resident: ignored.
- Reset mid-WAIT_LOAD: no commit, EMPTY immediately.
- Exactly one RegWriteW pulse per captured valid instruction with rd!=0 and RegWrite=1.

Optional Feature:
WB_PERF_CNT_EN:
- Defined: adds outputs retired_cnt[31:0] and load_stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on every commit cycle, including rd=0 or RegWrite=0 instructions.
  - load_stall_cnt increments each cycle stallW2H=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package wb_pkg: ResultSrc encodings (RS_ALU..RS_PC4), is_load function, state enum.
- One sub-module, load_align: combinational offset shift + sign/zero extension, parametrised by XLEN.
- FSM and pipeline register stay in the top.

Test Plan:
- validM=1, ResultSrcM=0, ALUOutM=0x1234, rdM=5, RegWriteM=1 -> next cycle RegWriteW=1, ResultW=0x1234, rdW=5, stallW2H=0.
- lb, ALUOutM=...02, mem_rdata=0x80FF_0000, mem_rvalid in W cycle -> ResultW=0xFFFFFFFF; same with lbu -> 0x000000FF.
- lhu, offset 2, rvalid delayed 3 cycles -> stallW2H high exactly 3 cycles; single RegWriteW pulse with ResultW=0x000080FF on cycle 4; M inputs held off meanwhile.
- rdM=0, RegWriteM=1, ALU op -> RegWriteW stays 0; flushW=1 on capture -> EMPTY, no commit.
- MAX_WAIT=4, rvalid withheld 6 cycles -> load_timeoutW rises after 4th wait cycle and stays set after commit.
- Assert reset during WAIT_LOAD -> outputs 0 asynchronously, no commit when rvalid later arrives. With WB_PERF_CNT_EN, counters return to 0.
